// File: rtl/fx3_chk_pkg.sv
// Shared types, default constants and the saturating-add helper for the FX3 loopback checker.
`default_nettype none

package fx3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } chk_state_t;

  localparam int unsigned CNT_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;

  // Clamps a + b to max_v; callers cast operands up to 32 bits and the result back down.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end
    return sum[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx3_chk_buf.sv
// Expected-word store for one loopback round: written in order, read in order at the read pointer.
`default_nettype none

module fx3_chk_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_adv_i,
  output logic [PTR_W-1:0]      wr_ptr_o,
  output logic [PTR_W-1:0]      rd_ptr_o,
  output logic [DATA_WIDTH-1:0] rd_word_o
);

  logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(BURST_LEN); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(BURST_LEN); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      for (int i = 0; i < int'(BURST_LEN); i++) begin
        if (wr_en_i && (wr_ptr_q == PTR_W'(i))) mem_q[i] <= wr_data_i;
      end
      if (wr_en_i)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_adv_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // The read pointer may sit one past the last entry; that slot reads as zero.
  always_comb begin
    rd_word_o = '0;
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      if (rd_ptr_q == PTR_W'(i)) rd_word_o = mem_q[i];
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/fx3_loopback_checker.sv
// Captures a burst written toward the FX3 and checks the loopback read-back in order,
// reporting pass/fail, error count, first failing word and a read-back timeout.
`default_nettype none

module fx3_loopback_checker
  import fx3_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  localparam int unsigned IDX_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  mismatch,
  output logic                  timeout,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [IDX_W-1:0]      first_bad_idx,
  output logic [DATA_WIDTH-1:0] first_bad_data
);

  localparam int unsigned PTR_W = $clog2(BURST_LEN + 1);
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t            state_q, state_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  timeout_q, timeout_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic                  mismatch_q, mismatch_d;
  logic                  first_seen_q, first_seen_d;
  logic [IDX_W-1:0]      fb_idx_q, fb_idx_d;
  logic [DATA_WIDTH-1:0] fb_data_q, fb_data_d;

  logic                  buf_clear, buf_wr, rd_acc, underflow, bad;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] exp_word;

  fx3_chk_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .PTR_W      (PTR_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (buf_clear),
    .wr_en_i   (buf_wr),
    .wr_data_i (wr_data),
    .rd_adv_i  (rd_acc),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .rd_word_o (exp_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      err_cnt_q    <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      first_seen_q <= 1'b0;
      fb_idx_q     <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      err_cnt_q    <= err_cnt_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      mismatch_q   <= mismatch_d;
      first_seen_q <= first_seen_d;
      fb_idx_q     <= fb_idx_d;
      fb_data_q    <= fb_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_cnt_d    = err_cnt_q;
    timer_d      = timer_q;
    timeout_d    = timeout_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    mismatch_d   = 1'b0;
    first_seen_d = first_seen_q;
    fb_idx_d     = fb_idx_q;
    fb_data_d    = fb_data_q;
    buf_clear    = 1'b0;
    buf_wr       = 1'b0;
    rd_acc       = 1'b0;
    underflow    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = COLLECT;
          buf_clear    = 1'b1;
          err_cnt_d    = '0;
          timer_d      = '0;
          timeout_d    = 1'b0;
          first_seen_d = 1'b0;
          fb_idx_d     = '0;
          fb_data_d    = '0;
        end
      end
      COLLECT: begin
        buf_wr = wr_valid;
        // Early reads compare against the pre-write pointer, so a same-cycle echo is an underflow.
        if (rd_valid) begin
          if (rd_ptr < wr_ptr) rd_acc = 1'b1;
          else                 underflow = 1'b1;
        end
        if (wr_valid && (wr_ptr == PTR_W'(BURST_LEN - 1))) begin
          state_d = WAIT_RD;
          timer_d = '0;
        end
      end
      WAIT_RD: begin
        if (rd_valid) begin
          rd_acc  = 1'b1;
          timer_d = '0;
          if (rd_ptr == PTR_W'(BURST_LEN - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          err_cnt_d = CNT_W'(sat_add(32'(err_cnt_q), 32'(BURST_LEN) - 32'(rd_ptr), 32'(CNT_MAX)));
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    bad        = rd_acc && (rd_data != exp_word);
    mismatch_d = bad;
    if (bad || underflow) begin
      err_cnt_d = CNT_W'(sat_add(32'(err_cnt_q), 32'd1, 32'(CNT_MAX)));
      if (!first_seen_q) begin
        first_seen_d = 1'b1;
        fb_idx_d     = underflow ? '0 : rd_ptr[IDX_W-1:0];
        fb_data_d    = rd_data;
      end
    end

    if (done_d) pass_d = (err_cnt_d == '0) && !timeout_d;
  end

  assign busy           = (state_q == COLLECT) || (state_q == WAIT_RD);
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch       = mismatch_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_bad_idx  = fb_idx_q;
  assign first_bad_data = fb_data_q;

endmodule

`default_nettype wire
